snes_pad_reader: RTL
====================

# snes_pad_reader

Multi-port SNES gamepad serial reader. It generates the shared latch and clock strobes, shifts in N_BITS per port on N_PORTS independent data lines, and publishes a coherent snapshot of every port together with a one-cycle frame strobe. It sits between the board-level pad connectors and the keypad and input-remap logic. Polling is either free-running at a fixed frame period or on demand.

## Interface
- `US_CYCLES`, default 100: clock cycles per microsecond.
- `PERIOD_US`, default 16667: latch-to-latch period in µs when auto-polling. Must be ≥ 18 + 12·N_BITS + 1.
- `N_PORTS`, default 2: number of pad ports, 1–4.
- `N_BITS`, default 16: bits per frame, 8–32. 16 is a standard pad, 32 is a mouse or extended device.
- `AUTO_POLL`, default 1: 1 = free-running timer, 0 = start only on `poll_req`.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `serial_data`  in  N_PORTS  pad data lines. Asynchronous. Low = pressed.
- `poll_req`  in  1  one-cycle start request. Used only when AUTO_POLL=0.
- `data_latch`  out  1  shared latch strobe, active-high.
- `data_clock`  out  1  shared shift clock. Idles high.
- `buttons`  out  N_PORTS·N_BITS  raw snapshot, active-low. Port p occupies [p·N_BITS +: N_BITS]; bit k is the k-th bit shifted in.
- `frame_valid`  out  1  one-cycle pulse on the cycle `buttons` updates.
- `busy`  out  1  high from latch start through the `frame_valid` cycle.

## Operation
- States: IDLE, LATCH, LWAIT, CLK_LO, CLK_HI.
- **IDLE**
  - Outputs: latch 0, clock 1.
  - AUTO_POLL=1: leave IDLE when the period timer reaches PERIOD_US·US_CYCLES−1. The timer is free-running and is not cleared by frames, so latch-to-latch spacing is exact.
  - AUTO_POLL=0: leave IDLE on `poll_req`=1. `poll_req` is ignored whenever `busy`=1.
- **LATCH**: `data_latch`=1 for 12·US_CYCLES cycles, then LWAIT.
- **LWAIT**: 6·US_CYCLES cycles, then CLK_LO.
- **CLK_LO**
  - `data_clock`=0 for 6·US_CYCLES cycles.
  - On the last CLK_LO cycle, each port's synchronised data is written into bit index bit_cnt of that port's shift register.
- **CLK_HI**
  - `data_clock`=1 for 6·US_CYCLES cycles.
  - At the end, bit_cnt increments.
  - If bit_cnt was N_BITS−1: go to IDLE, copy all shift registers to `buttons`, and pulse `frame_valid`. Otherwise go to CLK_LO.
- **Synchronisation**: each `serial_data` bit passes through a 2-flop synchroniser before sampling.
- **Counters**
  - The phase counter is wide enough for 12·US_CYCLES.
  - bit_cnt is $clog2(N_BITS) bits wide and cleared on entry to LATCH.
  - The period timer is $clog2(PERIOD_US·US_CYCLES) bits wide and wraps to 0.
- **Reset** (async, any state): state to IDLE, all counters 0.
  - Outputs: `data_latch`=0, `data_clock`=1, `buttons`=all 1s, `frame_valid`=0, `busy`=0.
  - A frame interrupted by reset is discarded and `buttons` is not partially updated.
- **poll_req on the frame_valid cycle**: ignored, because `busy`=1.

## Timing
- Let C = US_CYCLES and t=0 be the first LATCH cycle.
- Latch high on [0, 12C). Gap on [12C, 18C).
- Bit k:
  - Clock low on [18C+12Ck, 24C+12Ck).
  - Clock high on [24C+12Ck, 30C+12Ck).
  - Sampled at cycle 24C+12Ck−1.
- `frame_valid` and the `buttons` update occur at t = 18C+12C·N_BITS. With defaults that is 210C.
- AUTO_POLL=1: the first latch starts PERIOD_US·C cycles after reset deasserts.
- AUTO_POLL=0: latch starts the cycle after `poll_req` is sampled.
- `busy` is high for 18C+12C·N_BITS+1 cycles.

## Configuration
- Macro: `SNES_PRESS_EDGE_EN`.
- **Defined**
  - Adds output `pressed` (N_PORTS·N_BITS).
  - It pulses for one cycle, coincident with `frame_valid`, for each bit that went 1→0 between the previous and the new snapshot.
  - The previous snapshot resets to all 1s, so a button held at the first frame produces a pulse.
  - `pressed` resets to 0.
- **Undefined**: the port and the previous-snapshot register are absent. Core behaviour is unchanged.

## Structure
- Package `snes_pad_pkg` holds:
  - the state enum `snes_state_t`;
  - the timing constants `LATCH_US`=12, `GAP_US`=6, `HALF_US`=6.
- Sub-module `snes_port_shift` holds one port's synchroniser and N_BITS shift register, with inputs sample_en, bit_idx and clear.
- `snes_port_shift` is instantiated N_PORTS times in a generate loop.
- The FSM, counters and snapshot register are in the top module.

## Test plan
Bench setup: US_CYCLES=1, PERIOD_US=300, N_PORTS=2, N_BITS=16.
- Reset release with port0 model returning 0xFEFF (bit 8 low) and port1 idle 0xFFFF -> first latch at cycle 300; `frame_valid` at cycle 510; `buttons`=0xFFFF_FEFF.
- Free-run for 3 frames -> latch rising edges exactly 300 cycles apart; `data_clock` shows 16 low pulses of 6 cycles per frame.
- AUTO_POLL=0: `poll_req` pulse while idle -> latch starts next cycle. A second `poll_req` at t=100 -> ignored, only one frame produced.
- N_BITS=32 with port0 driving 0x7FFF_FFFF -> `frame_valid` at t=402; bit 31 of port0 reads 0.
- Reset asserted at t=150 mid-frame -> same cycle `data_clock`=1, `busy`=0, `buttons`=all 1s; no `frame_valid` for that frame.
- `SNES_PRESS_EDGE_EN` defined: frames 0xFFFF, 0xFFFE, 0xFFFE -> `pressed`[0] pulses only with the second `frame_valid`.

Source files
------------

// File: rtl/snes_pad_pkg.sv
// Shared types and timing constants for the SNES pad reader.
// Optional feature macro used by the top: SNES_PRESS_EDGE_EN.
package snes_pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LWAIT,
        CLK_LO,
        CLK_HI
    } snes_state_t;

    // Strobe durations in microseconds
    localparam int LATCH_US = 12;
    localparam int GAP_US   = 6;
    localparam int HALF_US  = 6;

endpackage

// File: rtl/snes_port_shift.sv
// One pad port: 2-flop synchroniser on the asynchronous data line plus an
// indexed N_BITS capture register. Bits are written by index, not shifted,
// so bit k of the register is always the k-th bit clocked out of the pad.
module snes_port_shift
    import snes_pad_pkg::*;
#(
    parameter int N_BITS = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      serial_in,
    input  logic                      sample_en,
    input  logic [$clog2(N_BITS)-1:0] bit_idx,
    input  logic                      clear,
    output logic [N_BITS-1:0]         shift_reg
);

    logic sync_meta;
    logic sync_out;

    // Two-stage synchroniser; idles at 1 (released button level)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            sync_out  <= sync_meta;
        end
    end

    // Capture register: cleared at frame start, one bit written per sample strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg <= '1;
        end else if (clear) begin
            shift_reg <= '1;
        end else if (sample_en) begin
            shift_reg[bit_idx] <= sync_out;
        end
    end

endmodule

// File: rtl/snes_pad_reader.sv
// Multi-port SNES gamepad reader: generates the shared latch/clock strobes,
// captures N_BITS per port and publishes a coherent snapshot with a
// one-cycle frame_valid strobe.
// Optional feature macro: SNES_PRESS_EDGE_EN adds the 'pressed' output
// (one-cycle 1->0 edge pulses per button, coincident with frame_valid).
module snes_pad_reader
    import snes_pad_pkg::*;
#(
    parameter int US_CYCLES = 100,
    parameter int PERIOD_US = 16667,
    parameter int N_PORTS   = 2,
    parameter int N_BITS    = 16,
    parameter int AUTO_POLL = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_PORTS-1:0]          serial_data,
    input  logic                        poll_req,
    output logic                        data_latch,
    output logic                        data_clock,
    output logic [N_PORTS*N_BITS-1:0]   buttons,
    output logic                        frame_valid,
    output logic                        busy
`ifdef SNES_PRESS_EDGE_EN
    ,
    output logic [N_PORTS*N_BITS-1:0]   pressed
`endif
);

    localparam int PHW = $clog2(LATCH_US * US_CYCLES + 1);
    localparam int TW  = $clog2(PERIOD_US * US_CYCLES);
    localparam int BW  = $clog2(N_BITS);

    localparam logic [PHW-1:0] LATCH_LAST = PHW'(LATCH_US * US_CYCLES - 1);
    localparam logic [PHW-1:0] GAP_LAST   = PHW'(GAP_US * US_CYCLES - 1);
    localparam logic [PHW-1:0] HALF_LAST  = PHW'(HALF_US * US_CYCLES - 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(PERIOD_US * US_CYCLES - 1);
    localparam logic [BW-1:0]  BIT_LAST   = BW'(N_BITS - 1);

    snes_state_t               state;
    snes_state_t               next_state;
    logic [PHW-1:0]            phase;
    logic [BW-1:0]             bit_cnt;
    logic [TW-1:0]             timer;
    logic [N_PORTS*N_BITS-1:0] shift_data;

    logic start_frame;
    logic phase_done;
    logic sample_en;
    logic bit_step;
    logic frame_done;
    logic go_request;

    // Start condition: free-running period timer, or an on-demand request
    // that is ignored while the previous frame is still being published
    assign go_request = (AUTO_POLL != 0) ? (timer == TIMER_LAST)
                                         : (poll_req && !frame_valid);

    // busy covers the whole frame including the publish cycle
    assign busy = (state != IDLE) || frame_valid;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and strobe outputs, all decoded from the current state
    always_comb begin
        next_state  = state;
        data_latch  = 1'b0;
        data_clock  = 1'b1;
        start_frame = 1'b0;
        phase_done  = 1'b0;
        sample_en   = 1'b0;
        bit_step    = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (go_request) begin
                    next_state  = LATCH;
                    start_frame = 1'b1;
                end
            end
            LATCH: begin
                data_latch = 1'b1;
                if (phase == LATCH_LAST) begin
                    next_state = LWAIT;
                    phase_done = 1'b1;
                end
            end
            LWAIT: begin
                if (phase == GAP_LAST) begin
                    next_state = CLK_LO;
                    phase_done = 1'b1;
                end
            end
            CLK_LO: begin
                data_clock = 1'b0;
                if (phase == HALF_LAST) begin
                    next_state = CLK_HI;
                    phase_done = 1'b1;
                    sample_en  = 1'b1;
                end
            end
            CLK_HI: begin
                if (phase == HALF_LAST) begin
                    phase_done = 1'b1;
                    bit_step   = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        next_state = IDLE;
                        frame_done = 1'b1;
                    end else begin
                        next_state = CLK_LO;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Phase counter: restarts at every state change, held at 0 while idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else if (phase_done || state == IDLE) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // Bit index: cleared as the latch begins, advanced at the end of each clock high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (start_frame) begin
            bit_cnt <= '0;
        end else if (bit_step) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Period timer: free-running so latch-to-latch spacing never drifts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (timer == TIMER_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Per-port synchroniser and capture register
    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        snes_port_shift #(
            .N_BITS(N_BITS)
        ) u_port (
            .clock    (clock),
            .reset    (reset),
            .serial_in(serial_data[p]),
            .sample_en(sample_en),
            .bit_idx  (bit_cnt),
            .clear    (start_frame),
            .shift_reg(shift_data[p*N_BITS +: N_BITS])
        );
    end

    // Snapshot register: only a fully completed frame reaches the outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buttons     <= '1;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                buttons <= shift_data;
            end
        end
    end

`ifdef SNES_PRESS_EDGE_EN
    // Press edges: bits released in the old snapshot and pressed in the new one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pressed <= '0;
        end else if (frame_done) begin
            pressed <= buttons & ~shift_data;
        end else begin
            pressed <= '0;
        end
    end
`endif

endmodule
